// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//
// Purpose:
//   Architectural register file at the writeback stage of a simple in-order
//   pipeline. It holds 31 x DATA_W registers for indices 1..31; index 0 is
//   hard-wired to zero and has no storage. One write port commits retiring
//   beats. Two combinational read ports serve decode. A registered forwarding
//   record describes the most recent commit, and a 16-bit counter tracks how
//   many writes have committed.
//
// Configuration macro:
//   WB_BYPASS_EN - when defined, a read port whose address matches the beat
//                  committing this cycle returns in_wbvalue combinationally.
//                  When undefined, read ports return stored contents only.
//
// Ports:
//   clock          in   1       rising-edge clock for all state
//   reset          in   1       asynchronous active-low reset
//   in_stall       in   1       beat is a bubble (discarded)
//   in_regdest     in   5       destination register index
//   in_writereg    in   1       beat writes in_regdest
//   in_wbvalue     in   DATA_W  value to write
//   in_rs_addr     in   5       read port A index
//   in_rt_addr     in   5       read port B index
//   out_rs_data    out  DATA_W  read port A data (combinational)
//   out_rt_data    out  DATA_W  read port B data (combinational)
//   out_fwd_valid  out  1       a write committed at the last edge
//   out_fwd_reg    out  5       index of the last committed write
//   out_fwd_value  out  DATA_W  value of the last committed write
//   out_wbcount    out  16      count of committed writes (wraps)
// -----------------------------------------------------------------------------
module writeback_regfile #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_stall,
   input  logic [4:0]        in_regdest,
   input  logic              in_writereg,
   input  logic [DATA_W-1:0] in_wbvalue,
   input  logic [4:0]        in_rs_addr,
   input  logic [4:0]        in_rt_addr,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic              out_fwd_valid,
   output logic [4:0]        out_fwd_reg,
   output logic [DATA_W-1:0] out_fwd_value,
   output logic [15:0]       out_wbcount
);

   // Register storage; index 0 is not stored.
   logic [DATA_W-1:0] r_regs [1:31];

   logic              r_fwd_valid_p1;
   logic [4:0]        r_fwd_reg_p1;
   logic [DATA_W-1:0] r_fwd_value_p1;
   logic [15:0]       r_wbcount_p1;

   logic              w_commit;
   logic [DATA_W-1:0] w_rs_stored;
   logic [DATA_W-1:0] w_rt_stored;

   // Writes to r0 are dropped here, so the register array never sees index 0.
   assign w_commit = in_writereg && !in_stall && (in_regdest != 5'd0);

   // ---- stage p0 -> p1: commit edge ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < 32; i++) begin
            r_regs[i] <= '0;
         end
         r_fwd_valid_p1 <= 1'b0;
         r_fwd_reg_p1   <= 5'd0;
         r_fwd_value_p1 <= '0;
         r_wbcount_p1   <= 16'd0;
      end else begin
         if (w_commit) begin
            r_regs[in_regdest] <= in_wbvalue;
            r_fwd_valid_p1     <= 1'b1;
            r_fwd_reg_p1       <= in_regdest;
            r_fwd_value_p1     <= in_wbvalue;
            r_wbcount_p1       <= r_wbcount_p1 + 16'd1;
         end else begin
            // Bubbles and r0 writes only drop the forwarding flag; the
            // index/value stay so consumers can still see the last commit.
            r_fwd_valid_p1 <= 1'b0;
         end
      end
   end

   // The guard keeps index 0 from selecting outside the stored range.
   assign w_rs_stored = (in_rs_addr == 5'd0) ? '0 : r_regs[in_rs_addr];
   assign w_rt_stored = (in_rt_addr == 5'd0) ? '0 : r_regs[in_rt_addr];

`ifdef WB_BYPASS_EN
   // w_commit already excludes index 0, so r0 still reads zero.
   always_comb begin
      out_rs_data = w_rs_stored;
      if (w_commit && (in_rs_addr == in_regdest)) begin
         out_rs_data = in_wbvalue;
      end
   end

   always_comb begin
      out_rt_data = w_rt_stored;
      if (w_commit && (in_rt_addr == in_regdest)) begin
         out_rt_data = in_wbvalue;
      end
   end
`else
   assign out_rs_data = w_rs_stored;
   assign out_rt_data = w_rt_stored;
`endif

   assign out_fwd_valid = r_fwd_valid_p1;
   assign out_fwd_reg   = r_fwd_reg_p1;
   assign out_fwd_value = r_fwd_value_p1;
   assign out_wbcount   = r_wbcount_p1;

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 in_stall  input  1  stall flag from the upstream stage register; high means the beat is a bubble.
REQ-005 in_regdest  input  5  destination register index of the retiring beat.
REQ-006 in_writereg  input  1  retiring beat writes in_regdest.
REQ-007 in_wbvalue  input  32  value to write.
REQ-008 in_rs_addr  input  5  read port A index.
REQ-009 in_rt_addr  input  5  read port B index.
REQ-010 out_rs_data  output  32  read port A data, combinational.
REQ-011 out_rt_data  output  32  read port B data, combinational.
REQ-012 out_fwd_valid  output  1  registered: a write committed last cycle.
REQ-013 out_fwd_reg  output  5  registered index of the last committed write.
REQ-014 out_fwd_value  output  32  registered value of the last committed write.
REQ-015 out_wbcount  output  16  registered count of committed writes.

Function
REQ-016 Storage SHALL be 31 x 32-bit registers for indices 1..31; index 0 SHALL always read 0 and never be stored.
REQ-017 A commit SHALL occur at a rising edge iff in_writereg=1, in_stall=0 and in_regdest!=0.
REQ-018 A commit SHALL update register[in_regdest] with in_wbvalue at that edge.
REQ-019 Beats with in_stall=1 SHALL be discarded, whatever in_writereg, in_regdest and in_wbvalue hold.
REQ-020 Beats with in_writereg=1 and in_regdest=0 SHALL be discarded.
REQ-021 Discarded beats SHALL change no state except out_fwd_valid, which SHALL clear to 0.
REQ-022 On a commit, out_fwd_valid, out_fwd_reg and out_fwd_value SHALL load 1, in_regdest and in_wbvalue at the same edge.
REQ-023 On any non-commit edge, out_fwd_valid SHALL load 0 and out_fwd_reg and out_fwd_value SHALL hold their values.
REQ-024 out_wbcount SHALL increment by 1 on each commit and wrap from 16'hFFFF to 16'h0000.
REQ-025 Read ports SHALL be fully combinational from the address and the stored state; both ports MAY address the same register.
REQ-026 Read latency SHALL be 0 cycles.
REQ-027 Write-to-read visibility SHALL be 1 cycle without bypass, 0 cycles with bypass (see REQ-031).

Reset
REQ-028 While reset=0, registers 1..31, out_fwd_valid, out_fwd_reg, out_fwd_value and out_wbcount SHALL be 0 immediately, independent of clock.
REQ-029 Reset asserted in the same cycle as a commit SHALL win; no write SHALL survive.
REQ-030 The first commit SHALL be possible at the first rising edge after reset deasserts.

Configuration
REQ-031 Macro WB_BYPASS_EN SHALL control same-cycle bypass.
- Defined: when a read address equals in_regdest, is nonzero, and the current beat would commit, that port SHALL return in_wbvalue combinationally.
- Not defined: read ports SHALL return stored contents only, so a same-cycle read returns the old value.

Verification
REQ-032 Reset: assert reset=0 mid-run after writing r5=32'hDEADBEEF -> out_rs_data(r5)=0, out_wbcount=0 and out_fwd_valid=0 immediately.
REQ-033 Basic write: regdest=3, writereg=1, stall=0, wbvalue=32'h12345678; one edge later rs_addr=3 -> 32'h12345678, fwd=(1,3,32'h12345678), wbcount=1.
REQ-034 Stall and r0:
- stall=1, regdest=7, writereg=1, value=32'hFFFF0000 -> r7 unchanged, fwd_valid=0, wbcount unchanged.
- regdest=0, writereg=1, value=32'hAAAA5555 -> r0 reads 0, wbcount unchanged.
REQ-035 Bypass: r9=32'h1, then same cycle regdest=9, value=32'h2, rs_addr=rt_addr=9.
- With WB_BYPASS_EN: both ports read 32'h2.
- Without WB_BYPASS_EN: both ports read 32'h1, then 32'h2 after the edge.
REQ-036 Counter wrap: preload by 65535 commits, then one more commit -> out_wbcount=16'h0000.
REQ-037 Back-to-back commits: r1=10 then r2=20 on consecutive edges -> fwd_valid stays 1 across both edges, and both registers read correctly.
